// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int REG_W   = 32;
    localparam int SEL_W   = 4;
    localparam int STALL_W = 6;

    // Stall vector encodings: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=reserved
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    // Byte-lane enables for a full-word fetch
    localparam logic [SEL_W-1:0] SEL_FULL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IBUS = 2'd1,
        ST_DBUS = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus watchdog: counts un-acknowledged transfer cycles and flags the last allowed one.
module bus_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Counter: cleared while the bus is idle, advances on every waited cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Expired on the final cycle the transfer is allowed to wait
    always_comb begin
        o_expired = (r_cnt == LAST_CYCLE);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and data access,
// with data-over-fetch priority, pipeline stall generation and watchdog abort.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [REG_W-1:0]   if_addr,
    output logic [REG_W-1:0]   if_rdata,
    output logic               if_done,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [SEL_W-1:0]   d_sel,
    input  logic [REG_W-1:0]   d_addr,
    input  logic [REG_W-1:0]   d_wdata,
    output logic [REG_W-1:0]   d_rdata,
    output logic               d_done,
    output logic               bus_req,
    output logic               bus_we,
    output logic [SEL_W-1:0]   bus_sel,
    output logic [REG_W-1:0]   bus_addr,
    output logic [REG_W-1:0]   bus_wdata,
    input  logic [REG_W-1:0]   bus_rdata,
    input  logic               bus_ack,
    output logic [STALL_W-1:0] stall,
    output logic               bus_err
);

    state_t             r_state;
    state_t             w_next;
    logic               r_owner_d;
    logic               r_err;
    logic               r_bus_we;
    logic [SEL_W-1:0]   r_bus_sel;
    logic [REG_W-1:0]   r_bus_addr;
    logic [REG_W-1:0]   r_bus_wdata;
    logic [REG_W-1:0]   r_if_rdata;
    logic [REG_W-1:0]   r_d_rdata;
    logic               w_busy;
    logic               w_expired;

    assign w_busy = (r_state == ST_IBUS) || (r_state == ST_DBUS);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state == ST_IDLE),
        .i_inc     (w_busy && !bus_ack),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: data wins over fetch; ack takes precedence over expiry
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (d_req) begin
                    w_next = ST_DBUS;
                end else if (if_req) begin
                    w_next = ST_IBUS;
                end
            end
            ST_IBUS, ST_DBUS: begin
                if (bus_ack || w_expired) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        bus_req = w_busy;
        if_done = (r_state == ST_RESP) && !r_owner_d;
        d_done  = (r_state == ST_RESP) &&  r_owner_d;
        bus_err = (r_state == ST_RESP) &&  r_err;
    end

    // Bus request latch on grant, read-data capture on ack, zero fill on timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_d   <= 1'b0;
            r_err       <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (d_req) begin
                r_owner_d   <= 1'b1;
                r_err       <= 1'b0;
                r_bus_we    <= d_we;
                r_bus_sel   <= d_sel;
                r_bus_addr  <= d_addr;
                r_bus_wdata <= d_wdata;
            end else if (if_req) begin
                r_owner_d   <= 1'b0;
                r_err       <= 1'b0;
                r_bus_we    <= 1'b0;
                r_bus_sel   <= SEL_FULL;
                r_bus_addr  <= if_addr;
                r_bus_wdata <= '0;
            end
        end else if (w_busy) begin
            if (bus_ack) begin
                if (r_state == ST_IBUS) begin
                    r_if_rdata <= bus_rdata;
                end else if (!r_bus_we) begin
                    r_d_rdata <= bus_rdata;
                end
            end else if (w_expired) begin
                r_err <= 1'b1;
                if (r_state == ST_IBUS) begin
                    r_if_rdata <= '0;
                end else begin
                    r_d_rdata <= '0;
                end
            end
        end
    end

    // Stall: a pending data access freezes up to MEM/WB, a pending fetch only PC and IF/ID
    always_comb begin
        stall = STALL_NONE;
        if (d_req && !d_done) begin
            stall = STALL_MEM;
        end else if (if_req && !if_done) begin
            stall = STALL_IF;
        end
    end

    assign bus_we    = r_bus_we;
    assign bus_sel   = r_bus_sel;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: random requester/memory stimulus,
// expected completions queued by the driver and checked by a separate monitor.
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [5:0]  stall;
    logic        bus_err;

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stall(stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        bit          err;
        logic [31:0] if_rd;
        logic [31:0] d_rd;
        int          done_cyc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_if = 32'h0;
    logic [31:0] m_d  = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: every completion pulse is matched against the oldest expected response
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            if (if_done || d_done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", {30'b0, if_done, d_done}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_port", {30'b0, if_done, d_done}, e.is_d ? 32'h1 : 32'h2);
                    chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    chk("done_err", 32'(bus_err), 32'(e.err));
                    chk("if_rdata", if_rdata, e.if_rd);
                    chk("d_rdata", d_rdata, e.d_rd);
                end
            end else if (bus_err) begin
                chk("stray_err", 32'(bus_err), 32'h0);
            end
        end
    end

    // Called at the negedge of the cycle in which the arbiter (idle) sees the request.
    task automatic run_bus(input bit is_d, input bit we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input bit ack, input logic [31:0] rd,
                           input bit if_pend);
        exp_t       e;
        logic [5:0] st_bus;
        st_bus = is_d ? 6'b011111 : 6'b000011;
        if (ack) begin
            if (!is_d) m_if = rd;
            else if (!we) m_d = rd;
        end else begin
            if (is_d) m_d = 32'h0;
            else m_if = 32'h0;
        end
        e.is_d = is_d; e.err = !ack; e.if_rd = m_if; e.d_rd = m_d;
        e.done_cyc = cyc + 2 + waits;
        sbq.push_back(e);
        #1 chk("stall_grant", 32'(stall), 32'(st_bus));
        for (int j = 0; j <= waits; j++) begin
            @(negedge clk);
            chk("bus_req_busy", 32'(bus_req), 32'h1);
            chk("stall_busy", 32'(stall), 32'(st_bus));
            chk("bus_we", 32'(bus_we), is_d ? 32'(we) : 32'h0);
            chk("bus_sel", 32'(bus_sel), is_d ? 32'(sel) : 32'hF);
            chk("bus_addr", bus_addr, addr);
            chk("bus_wdata", bus_wdata, is_d ? wdata : 32'h0);
            if (j == waits && ack) begin
                bus_ack = 1'b1; bus_rdata = rd;
            end else begin
                bus_ack = 1'b0; bus_rdata = $urandom;
            end
        end
        @(negedge clk);
        bus_ack = 1'b0;
        chk("bus_req_resp", 32'(bus_req), 32'h0);
        chk("stall_resp", 32'(stall), (is_d && if_pend) ? 32'h03 : 32'h00);
        if (is_d) d_req = 1'b0;
        else if_req = 1'b0;
    endtask

    task automatic issue_if(input logic [31:0] addr, input int waits, input bit ack,
                            input logic [31:0] rd);
        if_req = 1'b1; if_addr = addr;
        run_bus(1'b0, 1'b0, 4'hF, addr, 32'h0, waits, ack, rd, 1'b0);
    endtask

    task automatic issue_d(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input bit ack,
                           input logic [31:0] rd);
        d_req = 1'b1; d_we = we; d_sel = sel; d_addr = addr; d_wdata = wdata;
        run_bus(1'b1, we, sel, addr, wdata, waits, ack, rd, 1'b0);
    endtask

    task automatic issue_both(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                              input logic [31:0] wdata, input int dwaits, input bit dack,
                              input logic [31:0] drd, input logic [31:0] iaddr,
                              input int iwaits, input bit iack, input logic [31:0] ird);
        d_req = 1'b1; d_we = we; d_sel = sel; d_addr = addr; d_wdata = wdata;
        if_req = 1'b1; if_addr = iaddr;
        run_bus(1'b1, we, sel, addr, wdata, dwaits, dack, drd, 1'b1);
        @(negedge clk);
        run_bus(1'b0, 1'b0, 4'hF, iaddr, 32'h0, iwaits, iack, ird, 1'b0);
    endtask

    // Idle gap; a stray ack here must be ignored by the arbiter
    task automatic gap();
        int n;
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        end
        @(negedge clk);
        bus_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_sel = 4'h0; d_addr = 32'h0; d_wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_bus_sel", 32'(bus_sel), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_done_err", {29'b0, if_done, d_done, bus_err}, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        issue_if(32'h0000_0040, 0, 1'b1, 32'h3401_1100);
        gap();
        issue_both(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 2, 1'b1, 32'h5555_AAAA,
                   32'h44, 0, 1'b1, 32'hCAFE_0001);
        gap();
        issue_d(1'b0, 4'hF, 32'h200, 32'h0, 3, 1'b1, 32'h1234_5678);
        gap();
        issue_d(1'b0, 4'hF, 32'h300, 32'h0, TO - 1, 1'b0, 32'h0);
        gap();
        issue_if(32'h0000_0080, TO - 1, 1'b1, 32'h0BAD_F00D);
        gap();

        // Reset in the middle of a data transfer
        d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h400;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_bus_req", 32'(bus_req), 32'h1);
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h500;
        #1;
        chk("midrst_bus_req", 32'(bus_req), 32'h0);
        chk("midrst_bus_addr", bus_addr, 32'h0);
        chk("midrst_bus_sel", 32'(bus_sel), 32'h0);
        chk("midrst_done", {30'b0, if_done, d_done}, 32'h0);
        chk("midrst_stall", 32'(stall), 32'h1F);
        @(negedge clk);
        d_req = 1'b0;
        m_if = 32'h0; m_d = 32'h0;
        #1 chk("midrst_stall_if", 32'(stall), 32'h03);
        chk("midrst_rdata", if_rdata | d_rdata, 32'h0);
        rst = 1'b1;
        run_bus(1'b0, 1'b0, 4'hF, 32'h500, 32'h0, 1, 1'b1, 32'h7777_1234, 1'b0);
        gap();

        for (int t = 0; t < 60; t++) begin
            int  kind;
            int  w1, w2;
            bit  a1, a2;
            kind = $urandom_range(0, 3);
            a1 = ($urandom_range(0, 4) != 0);
            a2 = ($urandom_range(0, 4) != 0);
            w1 = a1 ? $urandom_range(0, TO - 1) : TO - 1;
            w2 = a2 ? $urandom_range(0, TO - 1) : TO - 1;
            case (kind)
                0: issue_if($urandom, w1, a1, $urandom);
                1: issue_d(1'b0, 4'($urandom), $urandom, $urandom, w1, a1, $urandom);
                2: issue_d(1'b1, 4'($urandom), $urandom, $urandom, w1, a1, $urandom);
                default: issue_both(1'($urandom), 4'($urandom), $urandom, $urandom, w1, a1,
                                    $urandom, $urandom, w2, a2, $urandom);
            endcase
            gap();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequential arbiter that shares a single-port instruction/data memory bus between the instruction-fetch stage and the memory-access stage of the five-stage pipeline. It serialises requests with data-over-fetch priority and drives a registered bus handshake. It generates the pipeline stall vector consumed by the pipeline registers, and aborts hung transfers with a watchdog timeout.

## Interface
Parameters:
- TIMEOUT, 16, bus cycles without `bus_ack` before a transfer is aborted (legal 2..255)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high until `if_done`
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word; valid while `if_done`=1, held afterwards
- if_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held high until `d_done`
- d_we  in  1  1 = store, 0 = load
- d_sel  in  4  byte-lane enables
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data; valid while `d_done`=1, held afterwards
- d_done  out  1  one-cycle completion pulse for data
- bus_req  out  1  bus transfer active
- bus_we, bus_sel, bus_addr, bus_wdata  out  1/4/32/32  registered copy of the granted request
- bus_rdata  in  32  read data, sampled on `bus_ack`
- bus_ack  in  1  transfer complete
- stall  out  6  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=reserved (always 0)
- bus_err  out  1  one-cycle pulse, coincident with `*_done`, when the transfer timed out

## Operation
- States: IDLE, IBUS, DBUS, RESP.
- IDLE: `d_req` → DBUS; else `if_req` → IBUS; else stay. On grant, latch the requester's address/we/sel/wdata into the bus registers (fetch: we=0, sel=4'b1111, wdata=0) and clear the watchdog counter.
- IBUS/DBUS: `bus_req`=1 and bus fields stable. On `bus_ack`, capture `bus_rdata` into `if_rdata` or `d_rdata` (loads only; stores leave `d_rdata` unchanged) → RESP. Without ack, increment the counter. When the counter reaches TIMEOUT-1 and no ack arrives, load 32'h0 into the rdata register, set the error flag → RESP.
- RESP: `bus_req`=0. Pulse `if_done` or `d_done` for the owner. Pulse `bus_err` if flagged → IDLE.
- Requester rule: a requester drops `*_req` (or presents a new request) on the edge ending its `*_done` cycle. The arbiter samples requests only in IDLE.
- `stall` (combinational from registered state and inputs): 6'b011111 if `d_req`=1 and `d_done`=0; else 6'b000011 if `if_req`=1 and `if_done`=0; else 6'b000000.
- Simultaneous `if_req` and `d_req` in IDLE: data first. Fetch is granted in the IDLE cycle after data RESP.
- `bus_ack` on the same cycle the counter hits TIMEOUT-1: ack wins, no error.
- `bus_ack` outside IBUS/DBUS is ignored.

## Timing
- Reset (rst=0, asynchronous, also mid-transfer): state IDLE, counter 0, `bus_req`/`bus_we`=0, `bus_sel`=0, `bus_addr`/`bus_wdata`=0, `if_rdata`/`d_rdata`=0, `*_done`=0, `bus_err`=0. `stall` follows its equation from the inputs. An in-flight transfer is dropped without a done pulse.
- Request sampled in IDLE at cycle N → `bus_req`=1 from N+1. Ack at cycle N+1+k → `*_done` at N+2+k.
- Zero-wait memory: 3 cycles from request to done. Back-to-back transfers are separated by ≥1 IDLE cycle.
- Timeout: `bus_req` high for exactly TIMEOUT cycles; done+err on the following cycle.
- Stall deasserts in the RESP cycle, so the pipeline advances on the edge that consumes `*_rdata`.

## Structure
- Shared defines: RegBus width (32), stall encodings STALL_NONE/STALL_IF/STALL_MEM, state encodings, bus_sel full-word constant.
- One sub-module: `bus_watchdog`, the clear/increment counter with a `expired` output parameterised by TIMEOUT. The FSM and registers stay in the top of the block.

## Test plan
- Fetch only, ack 0 waits: `if_req`, if_addr=32'h0000_0040, bus_rdata=32'h3401_1100 → `bus_req` at N+1, `if_done` at N+2 with `if_rdata`=32'h3401_1100, `stall`=6'b000011 for N..N+1.
- Simultaneous requests at N: data store addr 32'h100, wdata 32'hDEAD_BEEF, sel 4'b0011; 2-wait ack → `bus_we`=1 first, `d_done` at N+4, fetch `bus_req` at N+6, `stall`=6'b011111 until N+3.
- Load with 3 waits, bus_rdata=32'h1234_5678 → `d_rdata`=32'h1234_5678 at `d_done`, `if_rdata` unchanged.
- Timeout, TIMEOUT=4, no ack → `bus_req` high 4 cycles, then `d_done`=`bus_err`=1 with `d_rdata`=0, then IDLE.
- Ack on the final watchdog cycle → normal completion, `bus_err`=0.
- rst low during DBUS → all outputs at reset values immediately, no `d_done`. After release, a pending `if_req` is granted normally.
